button_conditioner: RTL
=======================

# button_conditioner

Front-end conditioning stage for the four push-buttons: start, stop, average and spare. It sits directly upstream of the averaging filter / reaction-timer core. Each raw, bouncing, asynchronous button input is synchronised and debounced. The block emits a clean level plus single-cycle press, release and long-press pulses, which the core consumes in place of its local edge detectors.

## Interface
Parameters:
- N_BTN, 4, number of independent button channels
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz); legal range ≥ 2
- LONG_CYCLES, 100000000, held duration after acceptance that raises long-press (1 s at 100 MHz); must be > DEBOUNCE_CYCLES

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- btn_in  input  N_BTN  raw button pins, asynchronous, active-high
- btn_level  output  N_BTN  debounced level per channel
- press_pulse  output  N_BTN  one-cycle pulse on accepted 0→1
- release_pulse  output  N_BTN  one-cycle pulse on accepted 1→0
- long_pulse  output  N_BTN  one-cycle pulse when held LONG_CYCLES after acceptance
- any_press  output  1  OR of press_pulse, registered in the same cycle as press_pulse

## Operation
- Channels are fully independent and identical.
- Each channel has a 2-FF synchroniser: s1 <= btn_in[i], s2 <= s1. Only s2 is used downstream.
- Per-channel FSM states: IDLE (level 0), PRESS_PEND, HELD (level 1), RELEASE_PEND.
- IDLE: if s2=1, go to PRESS_PEND and set db_cnt=1; otherwise db_cnt=0.
- PRESS_PEND:
  - s2=0: return to IDLE with db_cnt=0 (glitch rejected, no pulse).
  - s2=1 and db_cnt=DEBOUNCE_CYCLES-1: go to HELD, set btn_level=1, press_pulse=1 for one cycle, hold_cnt=0.
  - Otherwise increment db_cnt.
- HELD:
  - If s2=0, go to RELEASE_PEND with db_cnt=1.
  - hold_cnt increments every cycle in HELD and saturates at LONG_CYCLES.
  - The cycle hold_cnt reaches LONG_CYCLES, long_pulse=1 for exactly one cycle, once per press.
- RELEASE_PEND:
  - s2=1: return to HELD; hold_cnt keeps counting, not cleared.
  - s2=0 and db_cnt=DEBOUNCE_CYCLES-1: go to IDLE, set btn_level=0, release_pulse=1 for one cycle, clear hold_cnt.
  - hold_cnt continues counting while in RELEASE_PEND, so long_pulse may fire there.
- Counter widths: db_cnt $clog2(DEBOUNCE_CYCLES+1), hold_cnt $clog2(LONG_CYCLES+1). No wrap is permitted; hold_cnt saturates.
- press_pulse and release_pulse are never both high on the same channel in the same cycle.
- long_pulse never coincides with press_pulse.

## Timing
- Reset (rst=0) asynchronously clears:
  - all outputs to 0
  - synchronisers to 0
  - FSMs to IDLE
  - all counters to 0
- A button held through reset deassertion is treated as a fresh press. press_pulse fires DEBOUNCE_CYCLES+2 edges after the first edge with rst=1.
- Press latency: the first edge sampling btn_in=1 into s1 is edge 0. press_pulse and btn_level rise after edge DEBOUNCE_CYCLES+2 (2 synchroniser edges plus DEBOUNCE_CYCLES samples of s2=1).
- Release latency is the same: DEBOUNCE_CYCLES+2 edges.
- long_pulse asserts LONG_CYCLES edges after the edge that asserted press_pulse.
- All outputs are registered; no combinational path from btn_in to any output.
- Reset asserted mid-debounce or mid-hold aborts immediately, with no pulse emitted on exit from reset.

## Test plan
Run with N_BTN=4, DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
1. Clean press: btn_in[0] goes to 1 and stays. Required: press_pulse[0] is a single 1-cycle pulse at edge 10, btn_level[0]=1 from edge 10, any_press pulses at edge 10, other channels stay 0.
2. Bounce rejection: btn_in[1] toggles 1,0 every 3 cycles for 40 cycles, then stays 0. Required: no pulses on channel 1 and btn_level[1]=0 throughout. Then hold 1 for 20 cycles: exactly one press_pulse[1], 10 edges after the final rising sample.
3. Long press: hold btn_in[2]=1 for 60 cycles, then release. Required:
   - press_pulse at edge 10
   - long_pulse[2] one cycle at edge 42
   - release_pulse 10 edges after the falling sample
   - no second long_pulse
4. Short release glitch while held: btn_in[0] is held, drops to 0 for 5 cycles at hold_cnt≈10, then returns. Required: no release_pulse, btn_level stays 1, long_pulse still fires at edge 42.
5. Simultaneous channels: btn_in=4'b1111 rises in one cycle. Required: press_pulse=4'b1111 and any_press=1 in the same single cycle.
6. Reset mid-operation: assert rst=0 during a held button's PRESS_PEND. Required: all outputs 0 immediately. With the button still held after rst=1, press_pulse fires at edge 10 after deassertion.

Source files
------------

// File: rtl/button_conditioner.sv
// Four-channel push-button front end: 2-FF synchroniser, debounce FSM and
// registered level / press / release / long-press outputs per channel.
module button_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic             any_press
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    HELD,
    RELEASE_PEND
  } state_t;

  logic [N_BTN-1:0] s1, s2;
  logic [N_BTN-1:0] ev_level, ev_press, ev_release, ev_long;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t              state;
    logic [DB_W-1:0]     db_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_inc;
    logic                long_hit;
    logic                lvl_q, press_q, release_q, long_q;

    // Saturating hold counter shared by HELD and RELEASE_PEND.
    always_comb begin
      hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);
      long_hit = (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state     <= IDLE;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        lvl_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        unique case (state)
          IDLE: begin
            if (s2[i]) begin
              state  <= PRESS_PEND;
              db_cnt <= DB_ONE;
            end else begin
              db_cnt <= '0;
            end
          end
          PRESS_PEND: begin
            if (!s2[i]) begin
              state  <= IDLE;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state    <= HELD;
              db_cnt   <= '0;
              hold_cnt <= '0;
              lvl_q    <= 1'b1;
              press_q  <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end
          HELD: begin
            if (!s2[i]) begin
              state  <= RELEASE_PEND;
              db_cnt <= DB_ONE;
            end
            hold_cnt <= hold_inc;
            long_q   <= long_hit;
          end
          RELEASE_PEND: begin
            if (s2[i]) begin
              state    <= HELD;
              db_cnt   <= '0;
              hold_cnt <= hold_inc;
              long_q   <= long_hit;
            end else if (db_cnt == DB_LAST) begin
              state     <= IDLE;
              db_cnt    <= '0;
              hold_cnt  <= '0;
              lvl_q     <= 1'b0;
              release_q <= 1'b1;
            end else begin
              db_cnt   <= db_cnt + DB_ONE;
              hold_cnt <= hold_inc;
              long_q   <= long_hit;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign ev_level[i]   = lvl_q;
    assign ev_press[i]   = press_q;
    assign ev_release[i] = release_q;
    assign ev_long[i]    = long_q;
  end

  // Output register stage: FSM accepts after DEBOUNCE_CYCLES+1 edges, so this
  // extra stage places every output at DEBOUNCE_CYCLES+2 edges, all aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_pulse    <= '0;
      any_press     <= 1'b0;
    end else begin
      btn_level     <= ev_level;
      press_pulse   <= ev_press;
      release_pulse <= ev_release;
      long_pulse    <= ev_long;
      any_press     <= |ev_press;
    end
  end

endmodule
